// File: rtl/riscv_pkg.sv
// Shared load/store definitions: memop encodings, LSU state type, byte-enable masks
// and the legality/alignment check applied when an access is accepted.
package riscv_pkg;

   localparam logic [2:0] MEMOP_B  = 3'b000;
   localparam logic [2:0] MEMOP_H  = 3'b001;
   localparam logic [2:0] MEMOP_W  = 3'b010;
   localparam logic [2:0] MEMOP_BU = 3'b100;
   localparam logic [2:0] MEMOP_HU = 3'b101;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   // Unsigned variants only exist for loads; halves and words must be naturally aligned.
   function automatic logic memop_ok(input logic [2:0] op, input logic is_store,
                                     input logic [1:0] off);
      case (op)
         MEMOP_B:  memop_ok = 1'b1;
         MEMOP_H:  memop_ok = ~off[0];
         MEMOP_W:  memop_ok = (off == 2'b00);
         MEMOP_BU: memop_ok = ~is_store;
         MEMOP_HU: memop_ok = ~is_store & ~off[0];
         default:  memop_ok = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_access_load_align.sv
// Load lane select with sign/zero extension of the returned bus word.
module lsu_load_align
   import riscv_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [2:0]  memop_i,
   input  logic [1:0]  addr_lo_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_l;
   logic [15:0] half_l;

   always_comb begin
      byte_l = rdata_i[{addr_lo_i, 3'b000} +: 8];
      half_l = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (memop_i)
         MEMOP_B:  data_o = {{24{byte_l[7]}}, byte_l};
         MEMOP_BU: data_o = {24'h000000, byte_l};
         MEMOP_H:  data_o = {{16{half_l[15]}}, half_l};
         MEMOP_HU: data_o = {16'h0000, half_l};
         MEMOP_W:  data_o = rdata_i;
         default:  data_o = '0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_access.sv
// Multi-cycle load/store unit: IDLE -> BUS -> DONE over a req/ready data bus.
// Optional bus-wait abort is enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_access
   import riscv_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              memtoreg,
   input  logic              memwr,
   input  logic [2:0]        memop,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              stall,
   output logic              done,
   output logic [31:0]       load_data,
   output logic              fault,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ready,
   input  logic [31:0]       bus_rdata
);

   lsu_state_t        state_q, state_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic              bus_we_q, bus_we_d;
   logic [3:0]        bus_be_q, bus_be_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic [2:0]        memop_q, memop_d;
   logic [1:0]        off_q, off_d;
   logic [31:0]       load_data_q, load_data_d;
   logic              fault_q, fault_d;

   logic              access;
   logic [3:0]        be_calc;
   logic [31:0]       wdata_calc;
   logic [31:0]       aligned;

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   lsu_load_align u_align (
      .rdata_i   (bus_rdata),
      .memop_i   (memop_q),
      .addr_lo_i (off_q),
      .data_o    (aligned)
   );

   assign access = start & (memtoreg | memwr);

   always_comb begin
      case (memop[1:0])
         2'b00: begin
            be_calc    = BE_BYTE << addr[1:0];
            wdata_calc = {4{wdata[7:0]}};
         end
         2'b01: begin
            be_calc    = BE_HALF << addr[1:0];
            wdata_calc = {2{wdata[15:0]}};
         end
         default: begin
            be_calc    = BE_WORD;
            wdata_calc = wdata;
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      bus_addr_d  = bus_addr_q;
      bus_we_d    = bus_we_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      memop_d     = memop_q;
      off_d       = off_q;
      load_data_d = load_data_q;
      fault_d     = fault_q;
`ifdef LSU_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (access) begin
               if (memop_ok(memop, memwr, addr[1:0])) begin
                  state_d     = BUS;
                  bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                  bus_we_d    = memwr;
                  bus_be_d    = be_calc;
                  bus_wdata_d = wdata_calc;
                  memop_d     = memop;
                  off_d       = addr[1:0];
`ifdef LSU_TIMEOUT_EN
                  cnt_d       = '0;
`endif
               end else begin
                  state_d     = DONE;
                  fault_d     = 1'b1;
                  load_data_d = '0;
               end
            end
         end
         BUS: begin
            if (bus_ready) begin
               state_d     = DONE;
               fault_d     = 1'b0;
               load_data_d = bus_we_q ? 32'h0 : aligned;
`ifdef LSU_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // Abort counts this cycle as the last permitted wait.
               state_d     = DONE;
               fault_d     = 1'b1;
               load_data_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bus_addr_q  <= '0;
         bus_we_q    <= 1'b0;
         bus_be_q    <= '0;
         bus_wdata_q <= '0;
         memop_q     <= '0;
         off_q       <= '0;
         load_data_q <= '0;
         fault_q     <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         bus_addr_q  <= bus_addr_d;
         bus_we_q    <= bus_we_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         memop_q     <= memop_d;
         off_q       <= off_d;
         load_data_q <= load_data_d;
         fault_q     <= fault_d;
`ifdef LSU_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   // Stall drops in DONE so the core retires and writes load_data that cycle.
   assign stall     = ((state_q == IDLE) & access) | (state_q == BUS);
   assign done      = (state_q == DONE);
   assign fault     = (state_q == DONE) & fault_q;
   assign bus_req   = (state_q == BUS);
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_be    = bus_be_q;
   assign bus_wdata = bus_wdata_q;
   assign load_data = load_data_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Randomized bench for lsu_mem_access against an arithmetic reference of the access rules.
module tb_lsu_mem_access;

   localparam int TMO = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, memtoreg, memwr;
   logic [2:0]  memop;
   logic [31:0] addr, wdata;
   logic        stall, done, fault;
   logic [31:0] load_data;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   int n_vec = 0;
   int n_err = 0;

   lsu_mem_access #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .memtoreg(memtoreg), .memwr(memwr),
      .memop(memop), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
      .load_data(load_data), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ready(bus_ready), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: what the bus and the core should see for one access.
   task automatic model(input bit st, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        output bit f, output logic [3:0] be,
                        output logic [31:0] bwd, output logic [31:0] lres);
      int off, size;
      bit uns;
      logic [31:0] v;
      off  = int'(a[1:0]);
      size = int'(op[1:0]);
      uns  = op[2];
      f    = 0;
      if (op == 3'b011 || op == 3'b110 || op == 3'b111) f = 1;
      if (st && uns) f = 1;
      if (size == 1 && (off % 2) != 0) f = 1;
      if (size == 2 && off != 0) f = 1;
      if (size == 0) begin
         be   = 4'(1 << off);
         bwd  = 32'(wd[7:0]) * 32'h01010101;
         v    = (rd >> (8 * off)) & 32'hFF;
         lres = (!uns && v >= 32'h80) ? v + 32'hFFFFFF00 : v;
      end else if (size == 1) begin
         be   = 4'(3 << off);
         bwd  = 32'(wd[15:0]) * 32'h00010001;
         v    = (rd >> (8 * off)) & 32'hFFFF;
         lres = (!uns && v >= 32'h8000) ? v + 32'hFFFF0000 : v;
      end else begin
         be   = 4'hF;
         bwd  = wd;
         lres = rd;
      end
      if (st || f) lres = 0;
   endtask

   task automatic do_access(input bit ld, input bit st, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int waits);
      bit f;
      logic [3:0] be;
      logic [31:0] bwd, lres;
      model(st, op, a, wd, rd, f, be, bwd, lres);
      @(posedge clk); #1;
      start = 1; memtoreg = ld; memwr = st; memop = op; addr = a; wdata = wd;
      bus_ready = 0; bus_rdata = $urandom;
      @(negedge clk);
      check("stall_accept", stall, 1);
      check("req_accept", bus_req, 0);
      @(posedge clk); #1;
      start = 0; memtoreg = 1'($urandom); memwr = 1'($urandom);
      memop = 3'($urandom); addr = $urandom; wdata = $urandom;
      if (!f) begin
         for (int k = 0; k <= waits; k++) begin
            bus_ready = (k == waits);
            bus_rdata = (k == waits) ? rd : $urandom;
            @(negedge clk);
            check("bus_req", bus_req, 1);
            check("bus_we", bus_we, st);
            check("bus_addr", bus_addr, {a[31:2], 2'b00});
            check("bus_be", bus_be, be);
            check("bus_wdata", bus_wdata, bwd);
            check("stall_bus", stall, 1);
            check("done_bus", done, 0);
            @(posedge clk); #1;
         end
      end
      bus_ready = 0;
      @(negedge clk);
      check("done", done, 1);
      check("fault", fault, f);
      check("load_data", load_data, lres);
      check("stall_done", stall, 0);
      check("req_done", bus_req, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("done_pulse", done, 0);
   endtask

   initial begin
      int hi;
      bit saw_done, saw_fault;
      rst_n = 0; start = 0; memtoreg = 0; memwr = 0; memop = 0; addr = 0; wdata = 0;
      bus_ready = 0; bus_rdata = 0;
      #23;
      check("rst_stall", stall, 0);
      check("rst_done", done, 0);
      check("rst_fault", fault, 0);
      check("rst_req", bus_req, 0);
      check("rst_we", bus_we, 0);
      check("rst_ld", load_data, 0);
      check("rst_addr", bus_addr, 0);
      check("rst_be", bus_be, 0);
      check("rst_wd", bus_wdata, 0);
      @(posedge clk); #1; rst_n = 1;

      // Directed cases.
      do_access(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0);
      do_access(1, 0, 3'b000, 32'h203, 32'h0, 32'h80112233, 3);
      do_access(1, 0, 3'b100, 32'h203, 32'h0, 32'h80112233, 3);
      do_access(1, 0, 3'b001, 32'h102, 32'h0, 32'h9ABC1234, 1);
      do_access(1, 0, 3'b101, 32'h102, 32'h0, 32'h9ABC1234, 0);
      do_access(0, 1, 3'b001, 32'h101, 32'h1234, 32'h0, 0);
      do_access(1, 1, 3'b000, 32'h1, 32'hA5, 32'h0, 2);
      do_access(1, 0, 3'b011, 32'h0, 32'h0, 32'h0, 0);

      // Non-memory instruction: no stall, no bus traffic.
      @(posedge clk); #1;
      start = 1; memtoreg = 0; memwr = 0;
      @(negedge clk);
      check("nonmem_stall", stall, 0);
      @(posedge clk); #1; start = 0;
      @(negedge clk);
      check("nonmem_req", bus_req, 0);
      check("nonmem_done", done, 0);

      // Reset while waiting on the bus.
      @(posedge clk); #1;
      start = 1; memtoreg = 1; memwr = 0; memop = 3'b010; addr = 32'h40;
      @(posedge clk); #1; start = 0;
      @(posedge clk); #1;
      @(negedge clk);
      check("pre_rst_req", bus_req, 1);
      #2; rst_n = 0; #1;
      check("rst_mid_req", bus_req, 0);
      check("rst_mid_stall", stall, 0);
      @(posedge clk); #1; rst_n = 1;
      do_access(1, 0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 0);

      // Random accesses.
      for (int i = 0; i < 60; i++) begin
         int r;
         r = $urandom_range(0, 2);
         do_access(r != 1, r != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, $urandom_range(0, 3));
      end

      // Bus never answers.
      @(posedge clk); #1;
      start = 1; memtoreg = 1; memwr = 0; memop = 3'b010; addr = 32'h80;
      @(posedge clk); #1; start = 0;
      hi = 0; saw_done = 0; saw_fault = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (done) begin
            saw_done = 1;
            saw_fault = fault;
            break;
         end
         if (bus_req) hi++;
      end
`ifdef LSU_TIMEOUT_EN
      check("tmo_cycles", hi, TMO);
      check("tmo_done", saw_done, 1);
      check("tmo_fault", saw_fault, 1);
      check("tmo_ld", load_data, 0);
`else
      check("wait_cycles", hi, 1000);
      check("wait_no_done", saw_done, 0);
      @(posedge clk); #1; bus_ready = 1; bus_rdata = 32'h11223344;
      @(negedge clk);
      check("wait_req", bus_req, 1);
      @(posedge clk); #1; bus_ready = 0;
      @(negedge clk);
      check("wait_done", done, 1);
      check("wait_fault", fault, 0);
      check("wait_ld", load_data, 32'h11223344);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
Multi-cycle load/store unit downstream of the control decoder. It consumes memtoreg/memwr/memop from the decoder and the effective address from the ALU. It drives a word-addressed data-memory bus with a req/ready handshake and byte enables, stalls the core while a transfer is outstanding, and returns the aligned, extended load result for write-back.

Parameters:
ADDR_W, 32, byte-address width of core and bus
TIMEOUT_CYCLES, 255, bus-wait limit before abort (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  core clock, rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  instruction in execute is valid this cycle
memtoreg  in  1  load request (from decoder)
memwr  in  1  store request (from decoder)
memop  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
addr  in  ADDR_W  effective byte address (ALU result)
wdata  in  32  rs2 store data
stall  out  1  hold PC/regfile write while high
done  out  1  one-cycle pulse, access complete
load_data  out  32  extended load result, valid while done=1
fault  out  1  with done: misaligned, illegal memop, or timeout
bus_req  out  1  bus request
bus_we  out  1  1=write
bus_addr  out  ADDR_W  word-aligned address, bits[1:0]=0
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_ready  in  1  slave accepts/returns data this cycle
bus_rdata  in  32  read word, valid when bus_ready=1

Behaviour:
- Reset: async on rst_n low; state IDLE; stall, done, fault, bus_req, bus_we=0; load_data, bus_addr, bus_be, bus_wdata=0. Reset mid-transfer drops bus_req immediately; the transfer is abandoned.
- access = start & (memtoreg | memwr). memwr has priority if both are high.
- States: IDLE, BUS, DONE.
- IDLE: on access, check the operation.
  - If legal and aligned: register bus_addr={addr[31:2],2'b00}, bus_we, bus_be, bus_wdata, latch memop and addr[1:0]; go to BUS.
  - Otherwise (memop 011/110/111, store memop bit2 set, half with addr[0]=1, word with addr[1:0]!=0): no bus activity; go to DONE with fault=1 and load_data=0.
- BUS: bus_req=1. All bus outputs are held stable until bus_ready.
  - On bus_ready: capture the load result into load_data (stores: load_data=0) and go to DONE.
  - bus_ready in the first BUS cycle is legal; there is no minimum wait.
- DONE: done=1 and fault as computed for one cycle; go to IDLE. A new access is only sampled in IDLE.
- stall = (IDLE & access) | BUS. stall=0 in DONE, so the core retires the instruction and writes load_data. Non-memory instructions see zero stall.
- Minimum latency: access seen in cycle N, bus_req in N+1 with ready in N+1, done in N+2. Each wait state adds one cycle.
- Byte enables: b: 0001<<addr[1:0]; h: 0011<<addr[1:0]; w: 1111.
- Store data: b: {4{wdata[7:0]}}; h: {2{wdata[15:0]}}; w: wdata.
- Loads select the lane by addr[1:0]:
  - b: sign-extend byte; bu: zero-extend byte.
  - h: sign-extend half; hu: zero-extend half.
  - w: full word.
- Loads use bus_be per the same rule; the slave may ignore it.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined: an 8+ bit wait counter clears on BUS entry and increments each BUS cycle without bus_ready. When it reaches TIMEOUT_CYCLES, the access is aborted: bus_req drops, then DONE with fault=1 and load_data=0.
- Undefined: no counter; BUS waits indefinitely for bus_ready.

Decomposition:
- Shared package riscv_pkg:
  - memop constants MEMOP_B/H/W/BU/HU
  - lsu_state_t enum {IDLE, BUS, DONE}
  - BE_BYTE/BE_HALF/BE_WORD base masks
- One sub-module, lsu_load_align: combinational lane select plus sign/zero extension (inputs bus_rdata, memop, addr[1:0]; output 32-bit data).

Test Plan:
- sw addr=0x104, wdata=0xDEADBEEF, bus_ready tied 1 -> bus_req in N+1 with be=1111, bus_addr=0x104, bus_wdata=0xDEADBEEF; done in N+2, fault=0; stall high in N and N+1 only.
- lb addr=0x203, bus_rdata=0x80112233, 3 wait states -> bus_be=1000; bus outputs stable for 4 BUS cycles; load_data=0xFFFFFF80. Repeat with lbu -> 0x00000080.
- lh addr=0x102, bus_rdata=0x9ABC1234 -> load_data=0xFFFF9ABC, be=1100. Repeat with lhu -> 0x00009ABC.
- sh addr=0x101 -> no bus_req; done one cycle after access with fault=1, load_data=0.
- rst_n low during BUS wait -> bus_req=0 asynchronously, state IDLE. After release, a new lw addr=0x0 completes normally.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4, bus_ready held 0 -> bus_req drops after 4 BUS cycles; done with fault=1. Without the macro -> still waiting after 1000 cycles.
